gf180mcu_fd_sc_mcu9t5v0__latsnq_bank: RTL and testbench

Clocked, parametrised successor to the single-bit set-type latch: a DEPTH-entry × WIDTH-bit register bank with per-entry active-low synchronous set-to-ones, one write port, a registered read port with optional write-through bypass, and a per-entry minimum-set-pulse-width checker. The checker replaces simulation-only width checks with synthesizable logic. The bank sits in MCU control/status blocks that need many preset-to-one flags, for example interrupt masks and power-domain enables.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_if.sv | 29 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_bank.sv | 103 ++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__latsnq_bank.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_if.sv
// Bus bundle for the preset-to-one register bank: write port, per-entry set,
// read port and the sticky set-pulse-width error flags.
interface gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic             E;
   logic [AW-1:0]    WADDR;
   logic [WIDTH-1:0] D;
   logic [DEPTH-1:0] SETN;
   logic             RE;
   logic [AW-1:0]    RADDR;
   logic             ERR_CLR;
   logic [WIDTH-1:0] Q;
   logic             QVALID;
   logic [DEPTH-1:0] ERR;

   modport master (
      output E, WADDR, D, SETN, RE, RADDR, ERR_CLR,
      input  Q, QVALID, ERR
   );

   modport slave (
      input  E, WADDR, D, SETN, RE, RADDR, ERR_CLR,
      output Q, QVALID, ERR
   );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_bank.sv
// DEPTH x WIDTH bank of preset-to-one registers with a registered read port,
// optional write-through bypass and a per-entry minimum set-pulse checker.
module gf180mcu_fd_sc_mcu9t5v0__latsnq_bank #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 4,
   parameter int BYPASS     = 1,
   parameter int MIN_SET_PW = 2
) (
   input logic CLK,
   input logic RN,
   gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(MIN_SET_PW + 1);
   localparam logic [CW-1:0]    CNT_MAX  = CW'(MIN_SET_PW);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
   localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZEROS    = {WIDTH{1'b0}};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [CW-1:0]    cnt_r [DEPTH];
   logic [DEPTH-1:0] err_r;
   logic [WIDTH-1:0] q_r;
   logic             qvalid_r;

   logic [WIDTH-1:0] rd_data_s;
   logic [DEPTH-1:0] viol_s;

   // Read mux; an address matching no entry falls through to all zeros.
   always_comb begin
      rd_data_s = ZEROS;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.RADDR == AW'(i)) begin
            if (!bus.SETN[i]) begin
               rd_data_s = ONES;
            end else if ((BYPASS != 0) && bus.E && (bus.WADDR == AW'(i))) begin
               rd_data_s = bus.D;
            end else begin
               rd_data_s = mem_r[i];
            end
         end else begin
            rd_data_s = rd_data_s;
         end
      end
   end

   // A nonzero count proves the previous sample was low, so SETN high now is a release edge.
   always_comb begin
      viol_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         viol_s[i] = bus.SETN[i] && (cnt_r[i] != CNT_ZERO) && (cnt_r[i] < CNT_MAX);
      end
   end

   // Storage entries, pulse-width counters and sticky error flags.
   always_ff @(posedge CLK) begin
      if (!RN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= ONES;
            cnt_r[i] <= CNT_ZERO;
         end
         err_r <= {DEPTH{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!bus.SETN[i]) begin
               mem_r[i] <= ONES;
            end else if (bus.E && (bus.WADDR == AW'(i))) begin
               mem_r[i] <= bus.D;
            end else begin
               mem_r[i] <= mem_r[i];
            end
            if (bus.SETN[i]) begin
               cnt_r[i] <= CNT_ZERO;
            end else if (cnt_r[i] < CNT_MAX) begin
               cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end
         // New violations win over a coincident clear.
         err_r <= (bus.ERR_CLR ? {DEPTH{1'b0}} : err_r) | viol_s;
      end
   end

   // Registered read port; QVALID pulses once per accepted read.
   always_ff @(posedge CLK) begin
      if (!RN) begin
         q_r      <= ONES;
         qvalid_r <= 1'b0;
      end else if (bus.RE) begin
         q_r      <= rd_data_s;
         qvalid_r <= 1'b1;
      end else begin
         q_r      <= q_r;
         qvalid_r <= 1'b0;
      end
   end

   assign bus.Q      = q_r;
   assign bus.QVALID = qvalid_r;
   assign bus.ERR    = err_r;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__latsnq_bank.sv
// Directed plus randomized bench for the preset-to-one register bank; drives
// BYPASS=1 and BYPASS=0 copies with the same stimulus against a cycle model.
module tb_gf180mcu_fd_sc_mcu9t5v0__latsnq_bank;
   localparam int W   = 8;
   localparam int N   = 4;
   localparam int MPW = 2;

   logic       clk;
   logic       rn;
   logic       e;
   logic [1:0] waddr;
   logic [7:0] d;
   logic [3:0] setn;
   logic       re;
   logic [1:0] raddr;
   logic       err_clr;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: stored words, consecutive-low run lengths, expected outputs.
   logic [7:0] mem_m [N];
   int         low_run [N];
   logic [3:0] err_m;
   logic [7:0] q1_m;
   logic [7:0] q0_m;
   logic       qv_m;

   gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_if #(.WIDTH(W), .DEPTH(N)) bus1 ();
   gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_if #(.WIDTH(W), .DEPTH(N)) bus0 ();

   assign bus1.E = e;        assign bus0.E = e;
   assign bus1.WADDR = waddr; assign bus0.WADDR = waddr;
   assign bus1.D = d;        assign bus0.D = d;
   assign bus1.SETN = setn;  assign bus0.SETN = setn;
   assign bus1.RE = re;      assign bus0.RE = re;
   assign bus1.RADDR = raddr; assign bus0.RADDR = raddr;
   assign bus1.ERR_CLR = err_clr; assign bus0.ERR_CLR = err_clr;

   gf180mcu_fd_sc_mcu9t5v0__latsnq_bank #(.WIDTH(W), .DEPTH(N), .BYPASS(1), .MIN_SET_PW(MPW))
      dut_byp (.CLK(clk), .RN(rn), .bus(bus1));
   gf180mcu_fd_sc_mcu9t5v0__latsnq_bank #(.WIDTH(W), .DEPTH(N), .BYPASS(0), .MIN_SET_PW(MPW))
      dut_nobyp (.CLK(clk), .RN(rn), .bus(bus0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs held across that edge.
   task automatic model_step();
      logic [7:0] base;
      logic [3:0] new_err;
      if (!rn) begin
         for (int i = 0; i < N; i++) begin
            mem_m[i]   = 8'hFF;
            low_run[i] = 0;
         end
         q1_m  = 8'hFF;
         q0_m  = 8'hFF;
         qv_m  = 1'b0;
         err_m = 4'h0;
      end else begin
         if (re) begin
            base = setn[raddr] ? mem_m[raddr] : 8'hFF;
            q0_m = base;
            q1_m = (setn[raddr] && e && (waddr == raddr)) ? d : base;
            qv_m = 1'b1;
         end else begin
            qv_m = 1'b0;
         end
         new_err = 4'h0;
         for (int i = 0; i < N; i++) begin
            if (setn[i] && (low_run[i] > 0) && (low_run[i] < MPW)) new_err[i] = 1'b1;
            low_run[i] = setn[i] ? 0 : low_run[i] + 1;
            if (!setn[i]) mem_m[i] = 8'hFF;
            else if (e && (int'(waddr) == i)) mem_m[i] = d;
         end
         err_m = (err_clr ? 4'h0 : err_m) | new_err;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_eq("q_bypass", {24'h0, bus1.Q}, {24'h0, q1_m});
      check_eq("q_nobypass", {24'h0, bus0.Q}, {24'h0, q0_m});
      check_eq("qvalid", {30'h0, bus1.QVALID, bus0.QVALID}, {30'h0, qv_m, qv_m});
      check_eq("err_bypass", {28'h0, bus1.ERR}, {28'h0, err_m});
      check_eq("err_nobypass", {28'h0, bus0.ERR}, {28'h0, err_m});
   endtask

   task automatic idle();
      rn = 1'b1; e = 1'b0; re = 1'b0; setn = 4'hF; err_clr = 1'b0;
      waddr = 2'd0; raddr = 2'd0; d = 8'h00;
   endtask

   initial begin
      idle();
      // Reset with random inputs for two cycles.
      for (int k = 0; k < 2; k++) begin
         rn = 1'b0; e = 1'($urandom); re = 1'($urandom); setn = 4'($urandom);
         d = 8'($urandom); waddr = 2'($urandom); raddr = 2'($urandom); err_clr = 1'($urandom);
         tick();
      end
      check_eq("rst_q", {24'h0, bus1.Q}, 32'h0000_00FF);
      check_eq("rst_qvalid", {31'h0, bus1.QVALID}, 32'h0);
      check_eq("rst_err", {28'h0, bus1.ERR}, 32'h0);
      idle();
      for (int i = 0; i < N; i++) begin
         re = 1'b1; raddr = 2'(i);
         tick();
         check_eq("rst_read", {24'h0, bus0.Q}, 32'h0000_00FF);
      end

      // Write then read back.
      idle(); e = 1'b1; waddr = 2'd2; d = 8'h5A; tick();
      idle(); re = 1'b1; raddr = 2'd2; tick();
      check_eq("wr_rd_q", {24'h0, bus0.Q}, 32'h0000_005A);
      check_eq("wr_rd_qv", {31'h0, bus0.QVALID}, 32'h1);
      idle(); tick();
      check_eq("qv_pulse", {31'h0, bus0.QVALID}, 32'h0);

      // Same-cycle write/read with and without bypass.
      idle(); e = 1'b1; waddr = 2'd1; d = 8'h00; tick();
      idle(); e = 1'b1; waddr = 2'd1; d = 8'h3C; re = 1'b1; raddr = 2'd1; tick();
      check_eq("bypass_on", {24'h0, bus1.Q}, 32'h0000_003C);
      check_eq("bypass_off", {24'h0, bus0.Q}, 32'h0000_0000);
      idle(); re = 1'b1; raddr = 2'd1; tick();
      check_eq("bypass_off_next", {24'h0, bus0.Q}, 32'h0000_003C);

      // Set beats a same-cycle write; held two cycles so no width error.
      for (int k = 0; k < 2; k++) begin
         idle(); setn = 4'b0111; e = 1'b1; waddr = 2'd3; d = 8'h00; re = 1'b1; raddr = 2'd3;
         tick();
         check_eq("set_prio_q", {24'h0, bus1.Q}, 32'h0000_00FF);
      end
      idle(); re = 1'b1; raddr = 2'd3; tick();
      check_eq("set_prio_stored", {24'h0, bus0.Q}, 32'h0000_00FF);
      check_eq("set_prio_err", {28'h0, bus0.ERR}, 32'h0);

      // Pulse-width checker.
      idle(); setn = 4'b1110; tick();
      idle(); tick();
      check_eq("short_pulse", {28'h0, bus0.ERR}, 32'h1);
      idle(); setn = 4'b1101; tick(); tick();
      idle(); tick();
      check_eq("legal_pulse", {28'h0, bus0.ERR}, 32'h1);
      idle(); err_clr = 1'b1; tick();
      check_eq("err_clr", {28'h0, bus0.ERR}, 32'h0);
      idle(); setn = 4'b1011; tick();
      idle(); err_clr = 1'b1; tick();
      check_eq("set_wins_clr", {28'h0, bus0.ERR}, 32'h4);

      // Reset mid-operation.
      idle(); rn = 1'b0; re = 1'b1; setn = 4'b1110; tick();
      check_eq("midrst_qv", {31'h0, bus0.QVALID}, 32'h0);
      check_eq("midrst_err", {28'h0, bus0.ERR}, 32'h0);
      idle(); setn = 4'b1110; tick();
      idle(); tick();
      check_eq("post_rst_pulse", {28'h0, bus0.ERR}, 32'h1);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         rn      = ($urandom_range(0, 39) != 0);
         e       = 1'($urandom);
         waddr   = 2'($urandom);
         raddr   = ($urandom_range(0, 3) == 0) ? waddr : 2'($urandom);
         d       = 8'($urandom);
         re      = 1'($urandom);
         err_clr = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < N; i++) begin
            setn[i] = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
